pad_reader: RTL

- Serial gamepad front end; produces the per-player control levels (right, left, jump, squat, defend) that feed the player movement block.
- Drives an NES-style pad: latch pulse, 8 clock pulses, 8 active-low data bits.
- Scans once per poll period.
- Outputs are registered and change only at the end of a complete scan, so the player block sees stable levels for a whole frame.

---
 rtl/game_pkg.sv | 50 +++++
 rtl/sync_2ff.sv | 28 ++
 rtl/pad_reader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game front-end blocks.
//   - Button bit positions of the NES pad scan word (raw_btn).
//   - pad_state_t: scan FSM state encoding used by pad_reader.
//   - Default pad timing constants (clk cycles at 50 MHz).
//   - decode_btn(): maps a committed scan word to player control levels.
package game_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int PAD_LATCH_CYC = 600;
    localparam int PAD_HALF_CYC  = 300;
    localparam int PAD_POLL_CYC  = 833333;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_COMMIT = 3'd4
    } pad_state_t;

    typedef struct packed {
        logic right;
        logic left;
        logic jump;
        logic squat;
        logic defend;
    } pad_ctrl_t;

    // Opposing directions cancel; jump wins over squat.
    function automatic pad_ctrl_t decode_btn(input logic [7:0] btn);
        pad_ctrl_t c;
        logic      jmp;
        jmp      = btn[BTN_A] | btn[BTN_UP];
        c.right  = btn[BTN_RIGHT] & ~btn[BTN_LEFT];
        c.left   = btn[BTN_LEFT] & ~btn[BTN_RIGHT];
        c.jump   = jmp;
        c.squat  = btn[BTN_DOWN] & ~jmp;
        c.defend = btn[BTN_B];
        return c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   d        in  asynchronous input
//   q        out synchronized output (RST_VAL while in reset)
// RST_VAL defaults to 1 so an active-low input reads "released" out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_reader.sv
// pad_reader: NES-style serial gamepad front end.
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   pad_data    in  serial pad data, asynchronous, low = pressed
//   pad_latch   out latch strobe to pad
//   pad_clk     out shift clock to pad, idles high
//   right/left/jump/squat/defend  out  player control levels
//   raw_btn     out last committed scan, active-high (bit0=A .. bit7=Right)
//   frame_done  out one-cycle pulse when the outputs update
// Build option: define PAD_DEBOUNCE_EN to commit a scan only when it
// matches the previous scan's bits.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for the poll counter to wrap
// ST_LATCH  | pad_latch high LATCH_CYC cycles, bit0 sampled on last
// ST_CLK_LO | pad_clk low HALF_CYC cycles
// ST_CLK_HI | pad_clk high HALF_CYC cycles, bit_idx sampled on last
// ST_COMMIT | one cycle, scan copied to outputs
module pad_reader
    import game_pkg::*;
#(
    parameter int LATCH_CYC = PAD_LATCH_CYC,
    parameter int HALF_CYC  = PAD_HALF_CYC,
    parameter int POLL_CYC  = PAD_POLL_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic       right,
    output logic       left,
    output logic       jump,
    output logic       squat,
    output logic       defend,
    output logic [7:0] raw_btn,
    output logic       frame_done
);

    localparam int PW     = $clog2(POLL_CYC);
    localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYC - 1);
    localparam logic [PHW-1:0] LATCH_LOAD = PHW'(LATCH_CYC - 1);
    localparam logic [PHW-1:0] HALF_LOAD  = PHW'(HALF_CYC - 1);

    pad_state_t     state, state_next;
    logic [PW-1:0]  poll_cnt;
    logic [PHW-1:0] phase_cnt;
    logic [PHW-1:0] phase_load;
    logic           load_en;
    logic           sample_en;
    logic           commit_en;
    logic           idx_inc;
    logic           do_commit;
    logic           start_req;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           pad_sync;
    pad_ctrl_t      ctl_q;
    pad_ctrl_t      ctl_next;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_data),
        .q     (pad_sync)
    );

    // Free-running poll counter; a zero count is the scan start request,
    // so the first scan starts on the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    assign start_req = (poll_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase timer is a down-counter; each timed state ends on terminal count 0.
    always_comb begin
        state_next = state;
        phase_load = '0;
        load_en    = 1'b0;
        sample_en  = 1'b0;
        commit_en  = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_next = ST_LATCH;
                    phase_load = LATCH_LOAD;
                    load_en    = 1'b1;
                end
            end
            ST_LATCH: begin
                if (phase_cnt == '0) begin
                    sample_en  = 1'b1;
                    idx_inc    = 1'b1;
                    state_next = ST_CLK_LO;
                    phase_load = HALF_LOAD;
                    load_en    = 1'b1;
                end
            end
            ST_CLK_LO: begin
                if (phase_cnt == '0) begin
                    state_next = ST_CLK_HI;
                    phase_load = HALF_LOAD;
                    load_en    = 1'b1;
                end
            end
            ST_CLK_HI: begin
                if (phase_cnt == '0) begin
                    sample_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_COMMIT;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = ST_CLK_LO;
                        phase_load = HALF_LOAD;
                        load_en    = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                commit_en  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            if (load_en) begin
                phase_cnt <= phase_load;
            end else if (phase_cnt != '0) begin
                phase_cnt <= phase_cnt - 1'b1;
            end

            if (state == ST_IDLE) begin
                bit_idx <= '0;
            end else if (idx_inc) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (sample_en) begin
                shreg[bit_idx] <= ~pad_sync;
            end
        end
    end

    // Pad strobes are registered from the next state so they are glitch-free
    // and line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
        end else begin
            pad_latch <= (state_next == ST_LATCH);
            pad_clk   <= (state_next != ST_CLK_LO);
        end
    end

`ifdef PAD_DEBOUNCE_EN
    logic [7:0] cand;
    logic       cand_valid;

    // Every completed scan becomes the new candidate; it only reaches the
    // outputs when it repeats the previous scan bit-for-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= '0;
            cand_valid <= 1'b0;
        end else if (commit_en) begin
            cand       <= shreg;
            cand_valid <= 1'b1;
        end
    end

    assign do_commit = commit_en && cand_valid && (shreg == cand);
`else
    assign do_commit = commit_en;
`endif

    assign ctl_next = decode_btn(shreg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_btn    <= '0;
            ctl_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= do_commit;
            if (do_commit) begin
                raw_btn <= shreg;
                ctl_q   <= ctl_next;
            end
        end
    end

    assign right  = ctl_q.right;
    assign left   = ctl_q.left;
    assign jump   = ctl_q.jump;
    assign squat  = ctl_q.squat;
    assign defend = ctl_q.defend;

endmodule
